pe3_irq_arbiter: RTL

//  Upstream request-capture stage for the 3-input priority encoder path.

---
 rtl/pe3_irq_arbiter_if.sv | 37 +++
 rtl/pe3_irq_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pe3_irq_arbiter_if.sv
// Request/grant bundle for the 3-input IRQ arbiter.
// The mask line exists only when IRQ_MASK_EN is defined.
interface pe3_irq_arbiter_if;
    logic [2:0] req;
    logic       ack;
    logic [1:0] code;
    logic       valid;
    logic [2:0] pending;
    logic       timeout;
`ifdef IRQ_MASK_EN
    logic [2:0] mask;
`endif

    modport master (
        output req,
        output ack,
`ifdef IRQ_MASK_EN
        output mask,
`endif
        input  code,
        input  valid,
        input  pending,
        input  timeout
    );

    modport slave (
        input  req,
        input  ack,
`ifdef IRQ_MASK_EN
        input  mask,
`endif
        output code,
        output valid,
        output pending,
        output timeout
    );
endinterface

// File: rtl/pe3_irq_arbiter.sv
// Sync + edge capture of 3 async IRQ lines, priority grant with valid/ack.
// Optional IRQ_MASK_EN adds a per-line grant mask.
module pe3_irq_arbiter #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    pe3_irq_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    localparam bit         TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0] sync_out;
    logic [2:0] prev_q;
    logic [2:0] rise;
    logic [2:0] pending_q, pending_d;
    logic [2:0] elig;
    logic [2:0] clr;
    logic [1:0] enc;
    logic [1:0] state_q, state_d;
    logic [1:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       tmo_q, tmo_d;
    logic [7:0] cnt_q, cnt_d;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev_q;

`ifdef IRQ_MASK_EN
    assign elig = pending_q & ~bus.mask;
`else
    assign elig = pending_q;
`endif

    always_comb begin
        if (elig[2]) begin
            enc = 2'd2;
        end else if (elig[1]) begin
            enc = 2'd1;
        end else begin
            enc = 2'd0;
        end
    end

    // A rise landing on the edge that clears the same bit keeps it pending.
    assign pending_d = (pending_q & ~clr) | rise;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        clr     = 3'b000;
        unique case (state_q)
            S_GRANT: begin
                if (bus.ack) begin
                    state_d = S_CLEAR;
                    valid_d = 1'b0;
                    code_d  = 2'd0;
                    clr     = 3'b001 << code_q;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    code_d  = 2'd0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_IDLE, S_CLEAR: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                code_d  = 2'd0;
                if (|elig) begin
                    state_d = S_GRANT;
                    valid_d = 1'b1;
                    code_d  = enc;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                code_d  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            prev_q    <= 3'b000;
            pending_q <= 3'b000;
            state_q   <= S_IDLE;
            code_q    <= 2'd0;
            valid_q   <= 1'b0;
            tmo_q     <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.req};
            prev_q    <= sync_out;
            pending_q <= pending_d;
            state_q   <= state_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.code    = code_q;
    assign bus.valid   = valid_q;
    assign bus.pending = pending_q;
    assign bus.timeout = tmo_q;
endmodule
